vsync_fsm: RTL and testbench
============================

VSYNC_FSM -- requirements
Module: vsync_fsm

Interface
REQ-001 Parameter LINES_PER_ROW, default 5: display lines per memory row (vertical downscale factor).
REQ-002 Parameter ROWS, default 96: memory rows per frame; row_addr width = 7.
REQ-003 Parameter ACTIVE_LINES, default 480: expected line_done pulses per display (R) phase; equals ROWS*LINES_PER_ROW.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 enable_state  input  1  one-cycle pulse from the vsync cycle counter; advances the vertical state.
REQ-007 line_done  input  1  one-cycle pulse from the horizontal stage at the end of each line.
REQ-008 vsync  output  1  vertical sync, active-low, 0 only in state P.
REQ-009 v_active  output  1  high only in state R (display region).
REQ-010 row_addr  output  7  memory row being displayed; meaningful when v_active=1.
REQ-011 frame_start  output  1  one-cycle pulse on every S->P transition.
REQ-012 line_err  output  1  sticky flag: an R phase ended with a line count other than ACTIVE_LINES.

Function
REQ-013 State register SHALL hold one of P (sync pulse), Q (back porch), R (display), S (front porch).
REQ-014 On a clock edge with enable_state=1 the state SHALL advance P->Q->R->S->P; with enable_state=0 it SHALL hold.
REQ-015 Transition latency SHALL be exactly one clock: the state changes on the edge that samples enable_state=1.
REQ-016 vsync and v_active SHALL be Moore decodes of the state register only (no input-to-output combinational path).
REQ-017 Internal sub_cnt (0..LINES_PER_ROW-1), row_addr, and line_cnt (9 bits) SHALL be cleared on every transition into R.
REQ-018 In R, each line_done pulse SHALL increment line_cnt; line_cnt SHALL saturate at 511.
REQ-019 In R, each line_done pulse SHALL increment sub_cnt; when sub_cnt=LINES_PER_ROW-1, sub_cnt SHALL wrap to 0 and row_addr SHALL increment.
REQ-020 row_addr SHALL saturate at ROWS-1; further row increments SHALL leave it at ROWS-1.
REQ-021 Outside R, line_done SHALL be ignored; sub_cnt, row_addr and line_cnt SHALL hold their values.
REQ-022 If enable_state and line_done are both 1 in R, the transition SHALL take priority and that line_done SHALL not be counted.
REQ-023 On the R->S transition, line_err SHALL be set if line_cnt != ACTIVE_LINES; once set it SHALL stay set until reset.
REQ-024 frame_start SHALL be a registered output, high for exactly the one cycle following the edge that performs S->P.
REQ-025 Multiple enable_state pulses on consecutive cycles SHALL each advance the state; there SHALL be no pulse filtering.

Reset
REQ-026 While reset=0: state=P, vsync=0, v_active=0, row_addr=0, sub_cnt=0, line_cnt=0, frame_start=0, line_err=0.
REQ-027 Reset assertion SHALL act immediately (asynchronous); deassertion SHALL be honoured on the next rising edge.
REQ-028 Reset asserted mid-frame (any state) SHALL return to state P with all values listed in REQ-026; no frame_start SHALL be generated.

Verification
REQ-029 After reset, drive 4 enable_state pulses 10 cycles apart -> vsync 0,1,1,1,0 and v_active 0,0,1,0,0 across the P,Q,R,S,P windows; frame_start=1 exactly one cycle after the 4th pulse.
REQ-030 In R, drive 480 line_done pulses -> row_addr steps 0..95, changing every 5th pulse; after R->S, line_err=0.
REQ-031 In R, drive 490 line_done pulses -> row_addr holds at 95 after pulse 480; after R->S, line_err=1 and it stays 1 through a further complete frame.
REQ-032 In R, drive enable_state and line_done together on the same cycle after 479 lines -> state becomes S, line_cnt=479, line_err=1.
REQ-033 Assert reset while in R with row_addr=40 -> outputs immediately take the REQ-026 values; after release, the first enable_state pulse moves the state to Q.
REQ-034 Drive line_done pulses in P, Q and S -> row_addr, sub_cnt and line_cnt are unchanged, and v_active stays 0.

Source files
------------

// File: rtl/vsync_fsm.sv
// -----------------------------------------------------------------------------
// vsync_fsm -- vertical timing state machine for a line-doubled/downscaled
// display. Walks the vertical phases P (sync) -> Q (back porch) -> R (display)
// -> S (front porch) on each enable_state pulse, tracks which memory row is
// being shown during R, and flags frames whose display phase saw the wrong
// number of lines.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   enable_state in   one-cycle pulse, advances the vertical phase
//   line_done    in   one-cycle pulse at the end of each horizontal line
//   vsync        out  active-low vertical sync (low only in P)
//   v_active     out  high only in R
//   row_addr     out  [6:0] memory row for the current display line
//   frame_start  out  one-cycle pulse after each S->P transition
//   line_err     out  sticky: an R phase ended with a bad line count
// -----------------------------------------------------------------------------
module vsync_fsm #(
  parameter int LINES_PER_ROW = 5,
  parameter int ROWS          = 96,
  parameter int ACTIVE_LINES  = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_state,
  input  logic       line_done,
  output logic       vsync,
  output logic       v_active,
  output logic [6:0] row_addr,
  output logic       frame_start,
  output logic       line_err
);

  localparam int ROW_W  = 7;
  localparam int LINE_W = 9;
  localparam int SUB_W  = (LINES_PER_ROW > 1) ? $clog2(LINES_PER_ROW) : 1;

  localparam logic [ROW_W-1:0]  ROW_MAX    = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0]  ROW_ONE    = ROW_W'(1);
  localparam logic [LINE_W-1:0] LINE_ONE   = LINE_W'(1);
  localparam logic [LINE_W-1:0] LINE_EXPECT = LINE_W'(ACTIVE_LINES);
  localparam logic [SUB_W-1:0]  SUB_LAST   = SUB_W'(LINES_PER_ROW - 1);
  localparam logic [SUB_W-1:0]  SUB_ONE    = SUB_W'(1);

  typedef enum logic [1:0] {
    ST_P = 2'd0,
    ST_Q = 2'd1,
    ST_R = 2'd2,
    ST_S = 2'd3
  } state_t;

  state_t            state;
  logic [SUB_W-1:0]  sub_cnt;
  logic [LINE_W-1:0] line_cnt;

  // Line counter sticks at all-ones so an overlong display phase cannot wrap
  // back around to a value that looks correct.
  function automatic logic [LINE_W-1:0] sat_inc_line(input logic [LINE_W-1:0] v);
    return (v == {LINE_W{1'b1}}) ? v : v + LINE_ONE;
  endfunction

  // Row address stops at the last memory row.
  function automatic logic [ROW_W-1:0] sat_inc_row(input logic [ROW_W-1:0] v);
    return (v >= ROW_MAX) ? ROW_MAX : v + ROW_ONE;
  endfunction

  // Moore decodes straight off the state register.
  assign vsync    = (state != ST_P);
  assign v_active = (state == ST_R);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_P;
      sub_cnt     <= '0;
      row_addr    <= '0;
      line_cnt    <= '0;
      frame_start <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (enable_state) begin
        // A phase change wins over a coincident line_done.
        unique case (state)
          ST_P: state <= ST_Q;
          ST_Q: begin
            state    <= ST_R;
            sub_cnt  <= '0;
            row_addr <= '0;
            line_cnt <= '0;
          end
          ST_R: begin
            state <= ST_S;
            if (line_cnt != LINE_EXPECT) line_err <= 1'b1;
          end
          ST_S: begin
            state       <= ST_P;
            frame_start <= 1'b1;
          end
        endcase
      end else if (state == ST_R && line_done) begin
        line_cnt <= sat_inc_line(line_cnt);
        if (sub_cnt == SUB_LAST) begin
          sub_cnt  <= '0;
          row_addr <= sat_inc_row(row_addr);
        end else begin
          sub_cnt <= sub_cnt + SUB_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_vsync_fsm.sv
module tb_vsync_fsm;

  localparam int LPR  = 5;
  localparam int NROW = 96;
  localparam int ACT  = 480;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable_state = 1'b0;
  logic       line_done = 1'b0;
  logic       vsync;
  logic       v_active;
  logic [6:0] row_addr;
  logic       frame_start;
  logic       line_err;

  vsync_fsm #(.LINES_PER_ROW(LPR), .ROWS(NROW), .ACTIVE_LINES(ACT)) dut (
    .clk(clk), .reset(reset), .enable_state(enable_state), .line_done(line_done),
    .vsync(vsync), .v_active(v_active), .row_addr(row_addr),
    .frame_start(frame_start), .line_err(line_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase number 0..3 (P,Q,R,S), number of lines counted in
  // the current/last display phase, and the sticky error / frame pulse.
  int m_ph;
  int m_n;
  bit m_err;
  bit m_fs;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_row();
    return (m_n / LPR > NROW - 1) ? NROW - 1 : m_n / LPR;
  endfunction

  function automatic int exp_lcnt();
    return (m_n > 511) ? 511 : m_n;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_n = 0; m_err = 0; m_fs = 0;
  endtask

  task automatic model_edge(input bit es, input bit ld);
    m_fs = 0;
    if (es) begin
      if (m_ph == 1) m_n = 0;
      if (m_ph == 2 && m_n != ACT) m_err = 1;
      if (m_ph == 3) m_fs = 1;
      m_ph = (m_ph + 1) % 4;
    end else if (m_ph == 2 && ld) begin
      m_n++;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " vsync"},       int'(vsync),        int'(m_ph != 0));
    chk({tag, " v_active"},    int'(v_active),     int'(m_ph == 2));
    chk({tag, " row_addr"},    int'(row_addr),     exp_row());
    chk({tag, " frame_start"}, int'(frame_start),  int'(m_fs));
    chk({tag, " line_err"},    int'(line_err),     int'(m_err));
    chk({tag, " line_cnt"},    int'(dut.line_cnt), exp_lcnt());
    chk({tag, " sub_cnt"},     int'(dut.sub_cnt),  m_n % LPR);
  endtask

  // Drive inputs, take one rising edge, advance the model (no compare).
  task automatic tick(input bit es, input bit ld);
    enable_state = es;
    line_done    = ld;
    @(posedge clk);
    #1;
    model_edge(es, ld);
    enable_state = 1'b0;
    line_done    = 1'b0;
  endtask

  task automatic cyc(input string tag, input bit es, input bit ld);
    tick(es, ld);
    check_model(tag);
  endtask

  task automatic lines(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b1);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear
  // before any further edge.
  task automatic do_reset(input string tag);
    enable_state = 1'b0;
    line_done    = 1'b0;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_model({tag, " async"});
    @(posedge clk);
    #1;
    check_model({tag, " held"});
    reset = 1'b1;
  endtask

  typedef struct {
    bit       es;
    bit       ld;
    bit       vs;
    bit       va;
    bit [6:0] row;
    bit       fs;
    bit       err;
  } vec_t;

  vec_t vt[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // Table: walk a short frame, including ignored lines in P/Q/S and a
    // transition colliding with line_done. The 5-line R phase sets line_err.
    vt[0]  = '{0, 1, 0, 0, 7'd0, 0, 0};
    vt[1]  = '{1, 0, 1, 0, 7'd0, 0, 0};
    vt[2]  = '{0, 1, 1, 0, 7'd0, 0, 0};
    vt[3]  = '{1, 0, 1, 1, 7'd0, 0, 0};
    vt[4]  = '{0, 1, 1, 1, 7'd0, 0, 0};
    vt[5]  = '{0, 1, 1, 1, 7'd0, 0, 0};
    vt[6]  = '{0, 1, 1, 1, 7'd0, 0, 0};
    vt[7]  = '{0, 1, 1, 1, 7'd0, 0, 0};
    vt[8]  = '{0, 1, 1, 1, 7'd1, 0, 0};
    vt[9]  = '{1, 1, 1, 0, 7'd1, 0, 1};
    vt[10] = '{0, 1, 1, 0, 7'd1, 0, 1};
    vt[11] = '{1, 0, 0, 0, 7'd1, 1, 1};
    vt[12] = '{0, 0, 0, 0, 7'd1, 0, 1};

    // Power-on reset
    reset = 1'b0;
    #1;
    check_model("por");
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_model("por held");

    for (int i = 0; i < 13; i++) begin
      tick(vt[i].es, vt[i].ld);
      chk($sformatf("vec%0d vsync", i),       int'(vsync),       int'(vt[i].vs));
      chk($sformatf("vec%0d v_active", i),    int'(v_active),    int'(vt[i].va));
      chk($sformatf("vec%0d row_addr", i),    int'(row_addr),    int'(vt[i].row));
      chk($sformatf("vec%0d frame_start", i), int'(frame_start), int'(vt[i].fs));
      chk($sformatf("vec%0d line_err", i),    int'(line_err),    int'(vt[i].err));
      check_model($sformatf("vec%0d", i));
    end

    // Four pulses ten cycles apart: full P,Q,R,S,P cycle.
    do_reset("r29");
    for (int k = 0; k < 4; k++) begin
      cyc("r29 pulse", 1'b1, 1'b0);
      if (k == 3) chk("r29 frame_start after 4th", int'(frame_start), 1);
      for (int j = 0; j < 9; j++) cyc("r29 idle", 1'b0, 1'b0);
    end
    chk("r29 final vsync", int'(vsync), 0);

    // Exactly 480 lines: rows 0..95, no error.
    do_reset("r30");
    cyc("r30 toQ", 1'b1, 1'b0);
    cyc("r30 toR", 1'b1, 1'b0);
    for (int i = 0; i < ACT; i++) begin
      cyc("r30 line", 1'b0, 1'b1);
      if ($urandom_range(0, 3) == 0) cyc("r30 gap", 1'b0, 1'b0);
    end
    chk("r30 last row", int'(row_addr), 95);
    cyc("r30 toS", 1'b1, 1'b0);
    chk("r30 line_err", int'(line_err), 0);

    // 490 lines: row saturates, error sticks across the next frame, which
    // also overruns the 9-bit line counter.
    do_reset("r31");
    cyc("r31 toQ", 1'b1, 1'b0);
    cyc("r31 toR", 1'b1, 1'b0);
    lines("r31 line", 490);
    chk("r31 row sat", int'(row_addr), 95);
    cyc("r31 toS", 1'b1, 1'b0);
    chk("r31 line_err", int'(line_err), 1);
    cyc("r31 toP", 1'b1, 1'b0);
    cyc("r31 toQ2", 1'b1, 1'b0);
    cyc("r31 toR2", 1'b1, 1'b0);
    lines("r31 line2", 530);
    chk("r31 line_cnt sat", int'(dut.line_cnt), 511);
    cyc("r31 toS2", 1'b1, 1'b0);
    cyc("r31 toP2", 1'b1, 1'b0);
    chk("r31 line_err sticky", int'(line_err), 1);

    // Transition coincident with the 480th line: that line is dropped.
    do_reset("r32");
    cyc("r32 toQ", 1'b1, 1'b0);
    cyc("r32 toR", 1'b1, 1'b0);
    lines("r32 line", 479);
    cyc("r32 toS", 1'b1, 1'b1);
    chk("r32 line_cnt", int'(dut.line_cnt), 479);
    chk("r32 line_err", int'(line_err), 1);
    chk("r32 v_active", int'(v_active), 0);

    // Lines in P, Q and S leave counters alone.
    do_reset("r34");
    lines("r34 inP", 3);
    cyc("r34 toQ", 1'b1, 1'b0);
    lines("r34 inQ", 3);
    cyc("r34 toR", 1'b1, 1'b0);
    lines("r34 inR", 13);
    cyc("r34 toS", 1'b1, 1'b0);
    lines("r34 inS", 7);
    chk("r34 row held", int'(row_addr), 2);
    chk("r34 sub held", int'(dut.sub_cnt), 3);

    // Reset mid-display with row 40, then the first pulse goes to Q.
    do_reset("r33 pre");
    cyc("r33 toQ", 1'b1, 1'b0);
    cyc("r33 toR", 1'b1, 1'b0);
    lines("r33 line", 200);
    chk("r33 row40", int'(row_addr), 40);
    do_reset("r33");
    cyc("r33 idle", 1'b0, 1'b0);
    cyc("r33 first", 1'b1, 1'b0);
    chk("r33 vsync in Q", int'(vsync), 1);
    chk("r33 v_active in Q", int'(v_active), 0);

    // Randomised traffic, including back-to-back pulses and resets.
    do_reset("rnd");
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 2999) == 0) begin
        do_reset("rnd rst");
      end else begin
        cyc("rnd", ($urandom_range(0, 249) == 0) || (i % 1500 < 4),
            1'($urandom_range(0, 1)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
